// File: rtl/nibble_add_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the nibble-serial adder.
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the nibble index; a single-nibble build still needs one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/ripple_adder_4bit_structural.sv
// Four chained full adders; purely combinational 4-bit ripple-carry adder.
module ripple_adder_4bit_structural (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built by running one 4-bit ripple adder over NIBBLES slices, LSB nibble first.
// Optional subtract mode is compiled in with the NIBBLE_SUB_EN macro.
module nibble_serial_adder_ctrl
  import nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          carry_in,
`ifdef NIBBLE_SUB_EN
  input  logic                          sub,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          carry_out,
  output logic                          busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
  localparam logic [W-1:0]     NIB_MASK = W'({NIBBLE_W{1'b1}});

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;

  logic [IDX_W+1:0]    nib_sh_s;
  logic [W-1:0]        a_sh_s, b_sh_s;
  logic [NIBBLE_W-1:0] add_a_s, add_b_s, add_sum_s;
  logic                add_cout_s;
  logic                sub_in_s;

`ifdef NIBBLE_SUB_EN
  assign sub_in_s = sub;
`else
  assign sub_in_s = 1'b0;
`endif

  // Bit offset of the active nibble (idx * 4).
  assign nib_sh_s = {idx_q, 2'b00};
  assign a_sh_s   = a_q >> nib_sh_s;
  assign b_sh_s   = b_q >> nib_sh_s;
  assign add_a_s  = a_sh_s[NIBBLE_W-1:0];
  assign add_b_s  = sub_q ? ~b_sh_s[NIBBLE_W-1:0] : b_sh_s[NIBBLE_W-1:0];

  ripple_adder_4bit_structural u_adder (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (carry_q),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next-state, index and datapath register update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub_in_s;
          carry_d = sub_in_s ? 1'b1 : carry_in;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(NIB_MASK << nib_sh_s)) | (W'(add_sum_s) << nib_sh_s);
        carry_d = add_cout_s;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench: directed corner cases plus random adds against an arithmetic model.
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
`ifdef NIBBLE_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_sum;
  logic         exp_cout;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef NIBBLE_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: {cout,sum} = a + b + cin, or a - b as a + ~b + 1 when subtracting.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mcin, input logic msub);
    logic [W:0] r;
    if (msub) r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    else      r = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
    exp_sum  = r[W-1:0];
    exp_cout = r[W];
  endtask

  task automatic start_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic ocin, input logic osub);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = oa; b = ob; carry_in = ocin; in_valid = 1'b1;
`ifdef NIBBLE_SUB_EN
    sub = osub;
`endif
    model(oa, ob, ocin, osub);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
`ifdef NIBBLE_SUB_EN
    sub = 1'($urandom);
`endif
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result();
    for (int i = 1; i <= NIBBLES; i++) begin
      @(posedge clk); #1;
      if (i < NIBBLES) chk("out_valid_early", 32'(out_valid), 32'd0);
      else             chk("out_valid_latency", 32'(out_valid), 32'd1);
    end
    chk("sum", 32'(sum), 32'(exp_sum));
    chk("carry_out", 32'(carry_out), 32'(exp_cout));
  endtask

  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", 32'(sum), 32'(exp_sum));
      chk("hold_carry", 32'(carry_out), 32'(exp_cout));
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    // out_ready with no result pending must do nothing.
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_ready_noop", 32'(out_valid), 32'd0);

    start_op(16'h0000, 16'h0000, 1'b0, 1'b0);
    wait_result();
    release_result();

    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_result();
    chk("ripple_sum_const", 32'(sum), 32'h0000);
    chk("ripple_cout_const", 32'(carry_out), 32'd1);
    release_result();

    start_op(16'h1234, 16'h0FCD, 1'b1, 1'b0);
    wait_result();
    chk("mixed_sum_const", 32'(sum), 32'h2202);
    chk("mixed_cout_const", 32'(carry_out), 32'd0);

    // Back-pressure with a competing request pending the whole time.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h8001; b = 16'h7FFF; carry_in = 1'b1;
    hold_cycles(3);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", 32'(busy), 32'd1);
    model(16'h8001, 16'h7FFF, 1'b1, 1'b0);
    wait_result();
    release_result();

    // Reset while the third nibble is about to be processed.
    start_op(16'hABCD, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_carry", 32'(carry_out), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    start_op(16'h4321, 16'h5678, 1'b1, 1'b0);
    wait_result();
    release_result();

`ifdef NIBBLE_SUB_EN
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_result();
    chk("sub_neg_sum", 32'(sum), 32'hFFFE);
    chk("sub_neg_cout", 32'(carry_out), 32'd0);
    release_result();
    start_op(16'h0007, 16'h0005, 1'b1, 1'b1);
    wait_result();
    chk("sub_pos_sum", 32'(sum), 32'h0002);
    chk("sub_pos_cout", 32'(carry_out), 32'd1);
    release_result();
`endif

    for (int k = 0; k < 12; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
`ifdef NIBBLE_SUB_EN
      start_op(ra, rb, rc, 1'($urandom));
`else
      start_op(ra, rb, rc, 1'b0);
`endif
      wait_result();
      hold_cycles($urandom_range(0, 3));
      release_result();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs wide additions (NIBBLES×4 bits) by time-multiplexing a single `ripple_adder_4bit_structural` instance, one nibble per clock, least-significant nibble first. It latches the operands with a valid/ready handshake and chains carry through a registered carry flop. It presents the full result on a held valid/ready output port. It sits between an operand producer and a result consumer wherever a wide adder is needed but area favours one 4-bit adder.

## Interface
- NIBBLES, 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and carry_in presented.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  W  operand A.
- b  input  W  operand B.
- carry_in  input  1  carry into nibble 0.
- sub  input  1  subtract request (present only with NIBBLE_SUB_EN).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- carry_out  output  1  carry out of the top nibble.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready, register a, b and carry_in into carry_q.
  - Clear idx to 0 and go to RUN.
  - Operands are sampled only on this edge; later input changes are ignored.
- RUN:
  - Adder inputs are a_q[4*idx+:4], b_q[4*idx+:4] and carry_q.
  - Each edge writes the adder sum into sum_q[4*idx+:4] and the adder carry_out into carry_q, then increments idx.
  - When idx==NIBBLES-1, go to DONE instead of incrementing.
- DONE:
  - out_valid=1; sum=sum_q and carry_out=carry_q, both held stable.
  - On out_valid&out_ready, go to IDLE.
  - in_valid is ignored because in_ready=0.
- sum and carry_out are registered outputs. They keep their last value in IDLE and are valid to sample only when out_valid=1.
- Arithmetic: {carry_out,sum} = a + b + carry_in, modulo 2^(W+1). There is no overflow flag.
- idx width is clog2(NIBBLES), minimum 1. For NIBBLES=1, RUN lasts exactly one cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0; state=IDLE, idx=0, carry_q=0.
- Reset mid-operation: the in-flight operation is discarded asynchronously, with no partial result emitted. The first accept is possible on the first edge after rst deasserts.
- Latency: if operands are accepted on edge T, out_valid rises after edge T+NIBBLES.
- Minimum initiation interval is NIBBLES+2 cycles, with out_ready tied high.
- Back-pressure: out_valid stays high and sum stays stable for any number of cycles while out_ready=0.
- out_ready while out_valid=0 has no effect.
- Because in_ready is low in DONE, a result accept and a new operand accept never happen on the same edge.

## Configuration
- NIBBLE_SUB_EN defined:
  - The `sub` port exists and is registered with the operands.
  - When sub_q=1, the adder b input is ~b_q nibble and carry_q is initialised to 1, with carry_in ignored.
  - Result is a − b. carry_out=1 means no borrow.
- NIBBLE_SUB_EN undefined:
  - There is no `sub` port.
  - b passes through unmodified; addition only.

## Structure
- Package `nibble_add_pkg`:
  - Constant NIBBLE_W=4.
  - State enum {IDLE, RUN, DONE}.
  - Function for the idx width.
- One sub-module: the existing `ripple_adder_4bit_structural`, instantiated once and driven combinationally from the registered operand slice and carry_q.
- All other logic (FSM, idx counter, operand/result registers) is in this module.

## Test plan
- NIBBLES=4; a=0x0000, b=0x0000, carry_in=0 -> out_valid 4 edges after accept; sum=0x0000, carry_out=0.
- a=0xFFFF, b=0x0001, carry_in=0 (carry ripples through every nibble) -> sum=0x0000, carry_out=1.
- a=0x1234, b=0x0FCD, carry_in=1 -> sum=0x2202, carry_out=0; operands changed during RUN leave the result unaffected.
- Hold out_ready=0 for 3 cycles after out_valid, and pulse in_valid meanwhile -> sum held, in_ready=0, second request not accepted; it is accepted in IDLE after the release.
- Assert rst while idx==2 in RUN -> out_valid=0, sum=0, carry_out=0, in_ready=1 immediately; a new add then completes correctly.
- With NIBBLE_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry_out=0; a=0x0007, b=0x0005 -> sum=0x0002, carry_out=1.
